key_event_decoder: RTL

KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

---
 rtl/key_event_pkg.sv | 34 +++
 rtl/sync_fifo.sv | 48 ++++
 rtl/key_event_decoder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/key_event_pkg.sv
// Shared PS/2 set-2 decoder definitions: parser states, prefix/control bytes, event record.
package key_event_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_INIT     = 3'd0;
  localparam state_t ST_IDLE     = 3'd1;
  localparam state_t ST_GOT_E0   = 3'd2;
  localparam state_t ST_GOT_F0   = 3'd3;
  localparam state_t ST_GOT_E0F0 = 3'd4;

  localparam logic [7:0] BYTE_BAT    = 8'hAA;
  localparam logic [7:0] BYTE_EXT    = 8'hE0;
  localparam logic [7:0] BYTE_BRK    = 8'hF0;
  localparam logic [7:0] BYTE_PAUSE  = 8'hE1;
  localparam logic [7:0] BYTE_ACK    = 8'hFA;
  localparam logic [7:0] BYTE_RESEND = 8'hFE;
  localparam logic [7:0] BYTE_ECHO   = 8'hEE;
  localparam logic [7:0] BYTE_ERR0   = 8'h00;
  localparam logic [7:0] BYTE_ERR1   = 8'hFF;

  typedef struct packed {
    logic       is_repeat;
    logic       is_break;
    logic       ext;
    logic [7:0] code;
  } key_event_t;

  // Keyboard responses and the pause prefix never touch parser state.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == BYTE_ACK) || (b == BYTE_RESEND) || (b == BYTE_ECHO) || (b == BYTE_PAUSE);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through queue with extra-MSB pointers; head visible the cycle after a write.
// A write into a full queue is accepted only alongside a pop, otherwise it is dropped and flagged.
module sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             do_rd;
  logic             do_wr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign drop    = wr_en & full & ~do_rd;
  // Head reads as zero while empty so downstream never sees stale entries.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/key_event_decoder.sv
// PS/2 scan-byte parser tracking held keys and queueing make/break events.
// Bitmap updates on the byte's edge, event visible one cycle later; full queue drops and sets overflow.
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int REPORT_REPEAT = 0,
  parameter int REQUIRE_BAT   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid,
  output logic [8:0]   ev_code,
  output logic         ev_break,
  output logic         ev_repeat,
  output logic         ev_valid,
  input  logic         ev_ready,
  output logic [511:0] key_down,
  output logic [9:0]   keys_held,
  output logic         overflow,
  input  logic         clr_overflow,
  output logic         kb_ready
);

  state_t     state;
  state_t     state_nxt;
  logic       key_fire;
  logic       key_is_break;
  logic [8:0] key;
  logic       bat_seen;
  logic       hot_clear;
  logic       bit_was;

  logic       push;
  key_event_t push_ev;
  key_event_t head;
  logic       fifo_empty;
  logic       fifo_drop;

  always_comb begin
    state_nxt    = state;
    key_fire     = 1'b0;
    key_is_break = 1'b0;
    key          = '0;
    bat_seen     = 1'b0;
    hot_clear    = 1'b0;
    if (byte_valid && !is_ignored(byte_in)) begin
      if (state == ST_INIT) begin
        if (byte_in == BYTE_BAT) begin
          state_nxt = ST_IDLE;
          bat_seen  = 1'b1;
        end
      end else if (byte_in == BYTE_ERR0 || byte_in == BYTE_ERR1) begin
        state_nxt = ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (byte_in == BYTE_EXT)      state_nxt = ST_GOT_E0;
            else if (byte_in == BYTE_BRK) state_nxt = ST_GOT_F0;
            else if (byte_in == BYTE_BAT) hot_clear = 1'b1;
            else begin
              key_fire = 1'b1;
              key      = {1'b0, byte_in};
            end
          end
          ST_GOT_E0: begin
            if (byte_in == BYTE_BRK) state_nxt = ST_GOT_E0F0;
            else begin
              key_fire  = 1'b1;
              key       = {1'b1, byte_in};
              state_nxt = ST_IDLE;
            end
          end
          ST_GOT_F0: begin
            key_fire     = 1'b1;
            key_is_break = 1'b1;
            key          = {1'b0, byte_in};
            state_nxt    = ST_IDLE;
          end
          ST_GOT_E0F0: begin
            key_fire     = 1'b1;
            key_is_break = 1'b1;
            key          = {1'b1, byte_in};
            state_nxt    = ST_IDLE;
          end
          default: state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  assign bit_was = key_down[key];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= (REQUIRE_BAT != 0) ? ST_INIT : ST_IDLE;
      kb_ready  <= (REQUIRE_BAT == 0);
      key_down  <= '0;
      keys_held <= '0;
      push      <= 1'b0;
      push_ev   <= '0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (bat_seen) kb_ready <= 1'b1;

      if (hot_clear) begin
        key_down  <= '0;
        keys_held <= '0;
      end else if (key_fire) begin
        key_down[key] <= ~key_is_break;
        if (key_is_break && bit_was)        keys_held <= keys_held - 10'd1;
        else if (!key_is_break && !bit_was) keys_held <= keys_held + 10'd1;
      end

      // Staged one cycle so the queue entry lands after the bitmap update.
      push              <= key_fire & (key_is_break | ~bit_was | (REPORT_REPEAT != 0));
      push_ev.is_repeat <= key_fire & ~key_is_break & bit_was;
      push_ev.is_break  <= key_is_break;
      push_ev.ext       <= key[8];
      push_ev.code      <= key[7:0];

      if (fifo_drop)         overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(key_event_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (push_ev),
    .rd_en   (ev_ready),
    .rd_data (head),
    .empty   (fifo_empty),
    .drop    (fifo_drop)
  );

  assign ev_valid  = ~fifo_empty;
  assign ev_code   = {head.ext, head.code};
  assign ev_break  = head.is_break;
  assign ev_repeat = head.is_repeat;

endmodule
